// File: rtl/mult_pipe_reg.sv
// Purpose: DEPTH-stage valid/ready register pipeline of WIDTH-bit words with flush.
// Latency: a word accepted at edge N is on data_readReg after edge N+DEPTH-1 when it never stalls.
// Backpressure: a stage can take a word when it is empty or its successor moves the same edge, so in_ready drops only when every stage is full and read_ack is low.
//
// Ports:
//   clk            single clock, rising edge
//   ctrl_reset     synchronous active-low reset (clears valid and data)
//   data_writeReg  write data; write_to is its valid strobe, in_ready its ready
//   flush          drops every held word and any write at the same edge
//   data_readReg   output stage data; out_valid marks it valid, read_ack retires it
//   occupancy      number of valid stages, present only with MULT_PIPE_REG_OCC_EN
//
// Optional feature macro: MULT_PIPE_REG_OCC_EN (adds the occupancy port and counter).
module mult_pipe_reg #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             ctrl_reset,
    input  logic [WIDTH-1:0] data_writeReg,
    input  logic             write_to,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] data_readReg,
    output logic             out_valid,
    input  logic             read_ack
`ifdef MULT_PIPE_REG_OCC_EN
    ,
    output logic [3:0]       occupancy
`endif
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [WIDTH-1:0] dat_q   [DEPTH];
    logic [WIDTH-1:0] dat_d   [DEPTH];
    logic [WIDTH-1:0] src_dat [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] leave;
    logic [DEPTH-1:0] enter;
    logic             acc;

    always_comb begin
        // ready[k] = !valid[k] | ready[k+1] unrolled: stage k is ready when the
        // consumer acks or any stage from k to the output has a hole. Written
        // from vld_q alone so the chain has no combinational self-reference.
        rdy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rdy[k] = read_ack;
            for (int j = 0; j < DEPTH; j++) begin
                if (j >= k && !vld_q[j]) begin
                    rdy[k] = 1'b1;
                end
            end
        end
        rdy[DEPTH] = read_ack;

        acc = write_to & rdy[0] & ~flush;

        leave = '0;
        for (int k = 0; k < DEPTH; k++) begin
            leave[k] = vld_q[k] & rdy[k+1];
        end

        enter      = '0;
        enter[0]   = acc;
        src_dat[0] = data_writeReg;
        for (int k = 1; k < DEPTH; k++) begin
            enter[k]   = leave[k-1];
            src_dat[k] = dat_q[k-1];
        end

        vld_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            dat_d[k] = dat_q[k];
            if (flush) begin
                vld_d[k] = 1'b0;
            end else begin
                vld_d[k] = enter[k] | (vld_q[k] & ~leave[k]);
                // Data moves only with a word; stalled or emptied stages keep
                // their contents, which keeps data_readReg stable while idle.
                if (enter[k]) begin
                    dat_d[k] = src_dat[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!ctrl_reset) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < DEPTH; k++) begin
                dat_q[k] <= dat_d[k];
            end
        end
    end

    assign in_ready     = rdy[0];
    assign out_valid    = vld_q[DEPTH-1];
    assign data_readReg = dat_q[DEPTH-1];

`ifdef MULT_PIPE_REG_OCC_EN
    logic [3:0] occ_q;
    logic [3:0] occ_d;
    logic       retire;

    always_comb begin
        retire = leave[DEPTH-1];
        occ_d  = occ_q;
        if (flush) begin
            occ_d = 4'd0;
        end else if (acc && !retire) begin
            occ_d = occ_q + 4'd1;
        end else if (retire && !acc) begin
            occ_d = occ_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!ctrl_reset) begin
            occ_q <= 4'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule
